// File: rtl/keccak_msg_padder_pkg.sv
// Shared modes, rates and padding constants for the Keccak message padder.
package keccak_msg_padder_pkg;

  localparam int LANE_W    = 64;
  localparam int MAX_LANES = 21;
  localparam int IDX_W     = $clog2(MAX_LANES);

  localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END      = 8'h80;

  typedef enum logic [2:0] {
    CM_SHA3_224 = 3'd0,
    CM_SHA3_256 = 3'd1,
    CM_SHA3_384 = 3'd2,
    CM_SHA3_512 = 3'd3,
    CM_SHAKE128 = 3'd4,
    CM_SHAKE256 = 3'd5
  } cmode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FEED  = 3'd2,
    ST_PAD   = 3'd3,
    ST_DRAIN = 3'd4
  } pad_state_t;

  function automatic logic mode_legal(input logic [2:0] cmode);
    return (cmode <= 3'd5);
  endfunction

  function automatic logic [IDX_W-1:0] rate_lanes(input logic [2:0] cmode);
    logic [IDX_W-1:0] r;
    case (cmode_t'(cmode))
      CM_SHA3_224: r = 5'd18;
      CM_SHA3_256: r = 5'd17;
      CM_SHA3_384: r = 5'd13;
      CM_SHA3_512: r = 5'd9;
      CM_SHAKE128: r = 5'd21;
      CM_SHAKE256: r = 5'd17;
      default:     r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] suffix_byte(input logic [2:0] cmode);
    return (cmode >= 3'd4) ? SUFFIX_SHAKE : SUFFIX_SHA3;
  endfunction

endpackage

// File: rtl/keccak_msg_padder_if.sv
// Message beat stream from the system source into the padder.
interface keccak_msg_padder_if;

  logic [keccak_msg_padder_pkg::LANE_W-1:0] in_data;
  logic [3:0]                               in_bytes;
  logic                                     in_last;
  logic                                     in_valid;
  logic                                     in_ready;

  modport master (output in_data, in_bytes, in_last, in_valid, input in_ready);
  modport slave  (input in_data, in_bytes, in_last, in_valid, output in_ready);

endinterface

// File: rtl/keccak_msg_padder_pad_lane.sv
// Combinational lane builder: truncates a final beat, inserts the domain suffix and the closing pad bit.
module keccak_msg_padder_pad_lane
  import keccak_msg_padder_pkg::*;
(
  input  logic [LANE_W-1:0] data,
  input  logic [2:0]        n,
  input  logic              sfx_here,
  input  logic              last_lane,
  input  logic [7:0]        suffix,
  output logic [LANE_W-1:0] lane
);

  logic [LANE_W-1:0] body_s;

  // Bytes below n pass, byte n takes the suffix, bytes above are cleared
  always_comb begin
    body_s = data;
    if (sfx_here) begin
      for (int k = 0; k < LANE_W / 8; k++) begin
        if (3'(k) < n) begin
          body_s[8*k +: 8] = data[8*k +: 8];
        end else if (3'(k) == n) begin
          body_s[8*k +: 8] = suffix;
        end else begin
          body_s[8*k +: 8] = 8'h00;
        end
      end
    end else begin
      body_s = data;
    end
  end

  // The final lane of a padded block carries the closing pad bit in its top byte
  always_comb begin
    lane = body_s;
    if (last_lane) begin
      lane[LANE_W-1 -: 8] = body_s[LANE_W-1 -: 8] | PAD_END;
    end else begin
      lane[LANE_W-1 -: 8] = body_s[LANE_W-1 -: 8];
    end
  end

endmodule

// File: rtl/keccak_msg_padder.sv
// Keccak message padder: turns a beat stream into rate-sized lane blocks with suffix and pad10*1.
module keccak_msg_padder
  import keccak_msg_padder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               msg_start,
  input  logic [2:0]         cmode_i,
  keccak_msg_padder_if.slave msg,
  input  logic               core_req,
  output logic               core_wr,
  output logic [LANE_W-1:0]  core_dt,
  output logic               core_last_block,
  output logic               core_start,
  output logic [2:0]         core_cmode,
  output logic               busy,
  output logic               err_cmode
);

  pad_state_t        state_r;
  logic [2:0]        cmode_r;
  logic [IDX_W-1:0]  rate_r;
  logic [7:0]        sfx_byte_r;
  logic [IDX_W-1:0]  lane_idx_r;
  logic [LANE_W-1:0] lane_r;
  logic              lane_vld_r;
  logic              last_blk_r;
  logic              sfx_pend_r;
  logic              core_start_r;
  logic              busy_r;
  logic              err_cmode_r;

  logic              consume_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              pad_load_s;
  logic              fin_short_s;
  logic              at_end_s;
  logic              pad_s;
  logic              sfx_here_s;
  logic              last_lane_s;
  logic [IDX_W-1:0]  idx_inc_s;
  logic [IDX_W-1:0]  pos_s;
  logic [LANE_W-1:0] bld_data_s;
  logic [LANE_W-1:0] bld_lane_s;
  logic [2:0]        bld_n_s;

  // Handshakes and the in-block position of the next lane to be loaded
  always_comb begin
    consume_s   = lane_vld_r && core_req;
    in_ready_s  = (state_r == ST_FEED) && (!lane_vld_r || consume_s);
    accept_s    = msg.in_valid && in_ready_s;
    pad_load_s  = (state_r == ST_PAD) && (!lane_vld_r || consume_s);
    fin_short_s = msg.in_last && (msg.in_bytes < 4'd8);
    idx_inc_s   = (lane_idx_r == rate_r - 5'd1) ? {IDX_W{1'b0}} : lane_idx_r + 5'd1;
    // a held lane sits at lane_idx, so a new one lands right after it
    pos_s       = lane_vld_r ? idx_inc_s : lane_idx_r;
    at_end_s    = (pos_s == rate_r - 5'd1);
    if (state_r == ST_FEED) begin
      bld_data_s = msg.in_data;
      bld_n_s    = msg.in_bytes[2:0];
      sfx_here_s = fin_short_s;
      pad_s      = fin_short_s;
    end else begin
      bld_data_s = {LANE_W{1'b0}};
      bld_n_s    = 3'd0;
      sfx_here_s = sfx_pend_r;
      pad_s      = 1'b1;
    end
    last_lane_s = at_end_s && pad_s;
  end

  keccak_msg_padder_pad_lane u_pad_lane (
    .data      (bld_data_s),
    .n         (bld_n_s),
    .sfx_here  (sfx_here_s),
    .last_lane (last_lane_s),
    .suffix    (sfx_byte_r),
    .lane      (bld_lane_s)
  );

  // Message FSM with lane register, consumed-lane counter and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cmode_r      <= 3'd0;
      rate_r       <= {IDX_W{1'b0}};
      sfx_byte_r   <= 8'h00;
      lane_idx_r   <= {IDX_W{1'b0}};
      lane_r       <= {LANE_W{1'b0}};
      lane_vld_r   <= 1'b0;
      last_blk_r   <= 1'b0;
      sfx_pend_r   <= 1'b0;
      core_start_r <= 1'b0;
      busy_r       <= 1'b0;
      err_cmode_r  <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      err_cmode_r  <= 1'b0;
      if (consume_s) begin
        lane_idx_r <= idx_inc_s;
        lane_vld_r <= 1'b0;
        last_blk_r <= 1'b0;
      end else begin
        lane_idx_r <= lane_idx_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (msg_start && mode_legal(cmode_i)) begin
            state_r      <= ST_START;
            cmode_r      <= cmode_i;
            rate_r       <= rate_lanes(cmode_i);
            sfx_byte_r   <= suffix_byte(cmode_i);
            sfx_pend_r   <= 1'b0;
            core_start_r <= 1'b1;
            busy_r       <= 1'b1;
          end else if (msg_start) begin
            err_cmode_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          state_r <= ST_FEED;
        end
        ST_FEED: begin
          if (accept_s) begin
            lane_r     <= bld_lane_s;
            lane_vld_r <= 1'b1;
            last_blk_r <= pad_s;
            if (msg.in_last && fin_short_s) begin
              state_r <= at_end_s ? ST_DRAIN : ST_PAD;
            end else if (msg.in_last) begin
              // a full final beat pushes the suffix into the following lane
              state_r    <= ST_PAD;
              sfx_pend_r <= 1'b1;
            end else begin
              state_r <= ST_FEED;
            end
          end else begin
            state_r <= ST_FEED;
          end
        end
        ST_PAD: begin
          if (pad_load_s) begin
            lane_r     <= bld_lane_s;
            lane_vld_r <= 1'b1;
            last_blk_r <= 1'b1;
            sfx_pend_r <= 1'b0;
            state_r    <= at_end_s ? ST_DRAIN : ST_PAD;
          end else begin
            state_r <= ST_PAD;
          end
        end
        ST_DRAIN: begin
          if (consume_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          lane_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign msg.in_ready     = in_ready_s;
  assign core_wr          = lane_vld_r;
  assign core_dt          = lane_r;
  assign core_last_block  = last_blk_r;
  assign core_start       = core_start_r;
  assign core_cmode       = cmode_r;
  assign busy             = busy_r;
  assign err_cmode        = err_cmode_r;

endmodule
